// File: rtl/sprite_renderer_zoom.sv
// Scanline 1-bpp sprite renderer with per-sprite mirroring and 1x/2x/4x zoom.
// Define SPRITE_COLLISION_EN to add the playfield input and sticky collision output.
module sprite_renderer_zoom #(
  parameter int SPRITE_W = 16,
  parameter int SPRITE_H = 16,
  parameter int MAX_ZOOM = 2,
  localparam int RB = $clog2(SPRITE_H),
  localparam int BB = (SPRITE_W / 8 > 1) ? $clog2(SPRITE_W / 8) : 1,
  localparam int PB = $clog2(SPRITE_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vstart,
  input  logic               load,
  input  logic               hstart,
  input  logic               hmirror,
  input  logic               vmirror,
  input  logic [1:0]         zoom,
  output logic [RB+BB-1:0]   rom_addr,
  input  logic [7:0]         rom_bits,
  output logic               gfx,
  output logic               busy
`ifdef SPRITE_COLLISION_EN
  ,
  input  logic               playfield,
  output logic               collision
`endif
);

  // vstart/load/hstart are single-cycle strobes sampled on the rising edge;
  // each is only acted on in the state that waits for it, otherwise dropped.
  typedef enum logic [2:0] {
    IDLE, WAIT_LOAD, SETUP, CAPTURE, WAIT_HSTART, DRAW
  } state_t;

  localparam int            NBYTES    = SPRITE_W / 8;
  localparam logic [BB-1:0] LAST_BYTE = BB'(NBYTES - 1);
  localparam logic [PB-1:0] LAST_PX   = PB'(SPRITE_W - 1);
  localparam logic [RB-1:0] LAST_ROW  = RB'(SPRITE_H - 1);
  localparam logic [1:0]    ZMAX      = 2'(MAX_ZOOM);

  state_t              state;
  logic [SPRITE_W-1:0] linebuf;
  logic [RB-1:0]       row;
  logic [BB-1:0]       byte_idx;
  logic [PB-1:0]       px;
  logic [1:0]          pix_rep;
  logic [1:0]          line_rep;
  logic [1:0]          zoom_l;
  logic                hmirror_l;
  logic                vmirror_l;
  logic [1:0]          rep_max;
  logic [PB-1:0]       src_col;

  always_comb begin
    rep_max = 2'd0;
    case (zoom_l)
      2'd0:    rep_max = 2'd0;
      2'd1:    rep_max = 2'd1;
      default: rep_max = 2'd3;
    endcase
  end

  // SPRITE_W is a power of two, so SPRITE_W-1-px is just the bitwise complement.
  assign src_col = hmirror_l ? ~px : px;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      gfx       <= 1'b0;
      rom_addr  <= '0;
      linebuf   <= '0;
      row       <= '0;
      byte_idx  <= '0;
      px        <= '0;
      pix_rep   <= 2'd0;
      line_rep  <= 2'd0;
      zoom_l    <= 2'd0;
      hmirror_l <= 1'b0;
      vmirror_l <= 1'b0;
    end else begin
      gfx <= 1'b0;
      case (state)
        IDLE: begin
          if (vstart) begin
            hmirror_l <= hmirror;
            vmirror_l <= vmirror;
            zoom_l    <= (zoom > ZMAX) ? ZMAX : zoom;
            row       <= '0;
            line_rep  <= 2'd0;
            state     <= WAIT_LOAD;
          end
        end
        WAIT_LOAD: begin
          byte_idx <= '0;
          px       <= '0;
          pix_rep  <= 2'd0;
          if (load) state <= SETUP;
        end
        SETUP: begin
          rom_addr <= {(vmirror_l ? ~row : row), byte_idx};
          state    <= CAPTURE;
        end
        CAPTURE: begin
          for (int b = 0; b < NBYTES; b++) begin
            if (byte_idx == BB'(b)) linebuf[b*8 +: 8] <= rom_bits;
          end
          if (byte_idx == LAST_BYTE) begin
            state <= WAIT_HSTART;
          end else begin
            byte_idx <= byte_idx + 1'b1;
            state    <= SETUP;
          end
        end
        WAIT_HSTART: begin
          if (hstart) state <= DRAW;
        end
        DRAW: begin
          gfx <= linebuf[src_col];
          if (pix_rep == rep_max) begin
            pix_rep <= 2'd0;
            px      <= px + 1'b1;
            if (px == LAST_PX) begin
              // Replicated lines refetch the same row; the last copy advances it.
              if (line_rep < rep_max) begin
                line_rep <= line_rep + 2'd1;
                state    <= WAIT_LOAD;
              end else begin
                line_rep <= 2'd0;
                if (row == LAST_ROW) begin
                  state <= IDLE;
                end else begin
                  row   <= row + 1'b1;
                  state <= WAIT_LOAD;
                end
              end
            end
          end else begin
            pix_rep <= pix_rep + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPRITE_COLLISION_EN
  // Sticky until the next accepted vstart; a clear in the same cycle as a hit wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      collision <= 1'b0;
    end else if (state == IDLE && vstart) begin
      collision <= 1'b0;
    end else if (gfx && playfield) begin
      collision <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/sprite_renderer_zoom.md
Name: sprite_renderer_zoom

Overview:
- Parametrised next-generation scanline sprite renderer. Draws a SPRITE_W x SPRITE_H 1-bpp bitmap from a byte-wide ROM.
- Supports per-sprite horizontal and vertical mirroring and integer zoom (1x/2x/4x, pixel and line replication).
- Sits between a tank/object controller (which supplies vstart/hstart/load from position compares and hsync) and a combinational bitmap ROM.
- Its gfx bit is ORed into the RGB mixer.

Parameters:
- SPRITE_W, 16, sprite width in pixels; power of 2, >= 8.
- SPRITE_H, 16, sprite height in lines; power of 2, >= 2.
- MAX_ZOOM, 2, largest zoom exponent accepted (replication 2^MAX_ZOOM); 0..2.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- vstart  in  1  sprite's first display line reached (vpos == sprite y).
- load  in  1  start fetch of next row (typically hsync).
- hstart  in  1  sprite's first pixel column reached (hpos == sprite x).
- hmirror  in  1  mirror left/right; latched at vstart acceptance.
- vmirror  in  1  mirror top/bottom; latched at vstart acceptance.
- zoom  in  2  replication exponent; latched at vstart acceptance; clamped to MAX_ZOOM.
- rom_addr  out  RB+BB  byte address {row, byte_idx}. RB = log2(SPRITE_H); BB = log2(SPRITE_W/8), minimum 1 bit.
- rom_bits  in  8  ROM data, combinational from rom_addr. Bit 0 = leftmost pixel of that byte.
- gfx  out  1  registered pixel output.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async): state=IDLE, gfx=0, rom_addr=0, all counters 0, line buffer 0, latched mirror/zoom 0.
- States and transitions:
  - IDLE: on vstart, latch hmirror/vmirror/zoom (clamped), clear row/line-repeat counters -> WAIT_LOAD.
  - WAIT_LOAD: clear byte_idx, pixel counter and pixel-repeat counter; on load -> SETUP. load outside WAIT_LOAD is ignored.
  - SETUP: rom_addr <= {vmirror ? ~row : row, byte_idx} -> CAPTURE.
  - CAPTURE: linebuf[byte_idx*8 +: 8] <= rom_bits. If byte_idx == SPRITE_W/8-1 -> WAIT_HSTART; else byte_idx+1 -> SETUP.
  - WAIT_HSTART: on hstart -> DRAW. Waits indefinitely (no timeout).
  - DRAW: gfx <= linebuf[hmirror ? SPRITE_W-1-px : px]. pix_rep counts 0..2^z-1, and px advances when pix_rep wraps. After pixel SPRITE_W-1 with its last repeat, go to line-end handling.
- Line-end handling:
  - If line_rep < 2^z-1: line_rep+1, row unchanged (refetch same row) -> WAIT_LOAD.
  - Else line_rep=0. If row == SPRITE_H-1 -> IDLE; else row+1 -> WAIT_LOAD.
- Latency:
  - Fetch takes 2*(SPRITE_W/8) cycles after load is sampled.
  - First gfx pixel is high/low on the second rising edge after hstart is sampled in WAIT_HSTART.
  - Each line drives exactly SPRITE_W<<z gfx cycles. A sprite covers exactly SPRITE_H<<z lines.
- gfx is 0 in every cycle not in DRAW (default assignment each clock).
- Boundary conditions:
  - vstart while busy is ignored.
  - hstart during SETUP/CAPTURE is missed, and the renderer waits for the next hstart.
  - zoom > MAX_ZOOM behaves as MAX_ZOOM.
  - Mirror/zoom input changes mid-sprite have no effect until the next vstart.
  - reset mid-DRAW forces gfx=0 and busy=0 immediately (asynchronously).
- Width rules: px is log2(SPRITE_W) bits and row is RB bits, both wrapping naturally. pix_rep and line_rep are 2 bits.

Optional Feature:
- Macro: SPRITE_COLLISION_EN.
- Defined:
  - Adds input playfield (1) and output collision (1, registered).
  - collision is cleared to 0 on the cycle vstart is accepted in IDLE.
  - It is set when gfx && playfield is true in any cycle, and holds until the next accepted vstart.
  - Reset value 0. When clear and set coincide, clear wins.
- Not defined: neither port exists and there is no collision logic.

Test Plan:
- Defaults, zoom=0, no mirror, row r byte0=8'h01, byte1=8'h80, vstart then 16x (load, hstart). Expect per line: gfx=1 at pixel 0 and pixel 15 only; 16 lines; busy drops after last pixel; rom_addr sequence 0,1,2,3..31.
- Same ROM, hmirror=1, vmirror=1. Expect rom_addr first line {4'hF,0},{4'hF,1}; pixel pattern is symmetric and still 1 at px 0/15.
- Row 0 byte0=8'h03, rest 0, zoom=1. Expect 32-pixel lines with gfx=1 for cycles 0..3. Row 0 is drawn on 2 lines (two fetches at address 0/1). The sprite ends after 32 lines.
- zoom=3 with MAX_ZOOM=2. Expect 64-pixel lines and 64 lines (clamped to 4x).
- vstart pulsed again mid-sprite, and load pulsed during DRAW. Expect no state change and an unchanged rom_addr sequence. Assert reset during DRAW: gfx=0 and busy=0 before the next edge.
- With SPRITE_COLLISION_EN, playfield=1 only at pixel 15 of line 3 where gfx=1: collision rises the next edge, holds, and clears at the next accepted vstart. With playfield=1 where gfx=0: collision stays 0.
